// File: rtl/tlrb_aib_apb_master_if.sv
// Command/response handshake plus APB bus bundle for the TLRB AIB APB initiator.
// The master modport is the initiator's view; the slave modport is its counterpart.
interface tlrb_aib_apb_master_if #(
   parameter int AW = 12,
   parameter int DW = 32
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic          cmd_poll;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [DW-1:0] cmd_mask;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_err;
   logic          busy;

   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
      input  rsp_ready, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      output paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
      output rsp_ready, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      input  paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/tlrb_aib_apb_master.sv
// APB initiator for the TLRB AIB PHY config port: single write, read and
// read-poll commands in, one response (data + error code) out per command.
module tlrb_aib_apb_master #(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter int TIMEOUT  = 255,
   parameter int POLL_MAX = 1023
) (
   input  logic                  pclk,
   input  logic                  presetn,
   tlrb_aib_apb_master_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_POLL    = 2'b10;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state_reg;
   logic          cmd_ready_reg;
   logic          busy_reg;
   logic          psel_reg;
   logic          penable_reg;
   logic          pwrite_reg;
   logic [AW-1:0] paddr_reg;
   logic [DW-1:0] pwdata_reg;
   logic          rsp_valid_reg;
   logic [DW-1:0] rsp_rdata_reg;
   logic [1:0]    rsp_err_reg;
   logic          poll_reg;
   logic [DW-1:0] cmpv_reg;
   logic [DW-1:0] mask_reg;
   logic [TW-1:0] tcnt_reg;
   logic [PW-1:0] pcnt_reg;

   // A bit satisfies the poll when it is masked off or equals the compare value.
   logic [DW-1:0] bit_ok;
   logic          poll_hit;

   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_match
         assign bit_ok[gi] = ~mask_reg[gi] | (bus.prdata[gi] ~^ cmpv_reg[gi]);
      end
   endgenerate

   assign poll_hit = &bit_ok;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg     <= IDLE;
         cmd_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= ERR_OK;
         poll_reg      <= 1'b0;
         cmpv_reg      <= '0;
         mask_reg      <= '0;
         tcnt_reg      <= '0;
         pcnt_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.cmd_valid) begin
                  state_reg     <= SETUP;
                  cmd_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  psel_reg      <= 1'b1;
                  penable_reg   <= 1'b0;
                  paddr_reg     <= bus.cmd_addr;
                  pwrite_reg    <= bus.cmd_write;
                  pwdata_reg    <= bus.cmd_write ? bus.cmd_wdata : '0;
                  poll_reg      <= bus.cmd_poll & ~bus.cmd_write;
                  cmpv_reg      <= bus.cmd_wdata;
                  mask_reg      <= bus.cmd_mask;
                  pcnt_reg      <= PW'(1);
                  tcnt_reg      <= '0;
               end
            end

            SETUP: begin
               state_reg   <= ACCESS;
               penable_reg <= 1'b1;
            end

            ACCESS: begin
               if (bus.pready) begin
                  penable_reg   <= 1'b0;
                  rsp_rdata_reg <= pwrite_reg ? '0 : bus.prdata;
                  if (poll_reg && !poll_hit && (pcnt_reg < POLL_LAST)) begin
                     // Retry keeps psel high: the bus is not released between attempts.
                     state_reg <= SETUP;
                     pcnt_reg  <= pcnt_reg + 1'b1;
                     tcnt_reg  <= '0;
                  end else begin
                     state_reg     <= RESP;
                     psel_reg      <= 1'b0;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= (poll_reg && !poll_hit) ? ERR_POLL : ERR_OK;
                  end
               end else if (tcnt_reg == TO_LAST) begin
                  state_reg     <= RESP;
                  tcnt_reg      <= tcnt_reg + 1'b1;
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_rdata_reg <= '0;
                  rsp_err_reg   <= ERR_TIMEOUT;
               end else begin
                  tcnt_reg <= tcnt_reg + 1'b1;
               end
            end

            RESP: begin
               // Returning to IDLE first means a waiting command is taken a cycle later.
               if (bus.rsp_ready) begin
                  state_reg     <= IDLE;
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end
            end

            default: begin
               state_reg     <= IDLE;
               cmd_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
               psel_reg      <= 1'b0;
               penable_reg   <= 1'b0;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_reg;
   assign bus.busy      = busy_reg;
   assign bus.psel      = psel_reg;
   assign bus.penable   = penable_reg;
   assign bus.pwrite    = pwrite_reg;
   assign bus.paddr     = paddr_reg;
   assign bus.pwdata    = pwdata_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_tlrb_aib_apb_master.sv
// Bench for tlrb_aib_apb_master: scripted APB slave, protocol monitor and a
// command-level reference model; directed scenarios plus randomized commands.
module tb_tlrb_aib_apb_master;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam int PM = 4;

   logic pclk = 1'b0;
   logic presetn = 1'b1;

   tlrb_aib_apb_master_if #(.AW(AW), .DW(DW)) bus ();

   tlrb_aib_apb_master #(.AW(AW), .DW(DW), .TIMEOUT(TO), .POLL_MAX(PM)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Slave script: per access index, cycles of pready low before completion, and data.
   int            slv_wait [8];
   logic [DW-1:0] slv_data [8];
   int            setups_seen = 0;
   int            pen_cnt = 0;
   int            psel_falls = 0;
   int            viol = 0;
   int            cur = 0;
   int            acc_cyc = 0;
   logic          prev_psel = 1'b0;
   logic          prev_pen = 1'b0;
   logic [AW-1:0] s_addr = '0;
   logic          s_wr = 1'b0;
   logic [DW-1:0] s_wd = '0;

   always @(posedge pclk) cyc++;

   always @(negedge pclk) begin
      if (bus.penable === 1'b1 && bus.psel !== 1'b1) viol++;
      if (bus.penable === 1'b1 && !prev_pen && !(prev_psel && !prev_pen)) viol++;
      if (prev_psel && bus.psel === 1'b0) psel_falls++;
      if (bus.psel === 1'b1 && bus.penable === 1'b0) begin
         cur = (setups_seen < 8) ? setups_seen : 7;
         setups_seen++;
         acc_cyc = 0;
         s_addr = bus.paddr;
         s_wr   = bus.pwrite;
         s_wd   = bus.pwdata;
         if (!bus.pwrite && bus.pwdata !== '0) viol++;
      end
      if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
         pen_cnt++;
         if (bus.paddr !== s_addr || bus.pwrite !== s_wr || bus.pwdata !== s_wd) viol++;
         if (acc_cyc == slv_wait[cur]) begin
            bus.pready = 1'b1;
            bus.prdata = slv_data[cur];
         end else begin
            bus.pready = 1'b0;
            bus.prdata = $urandom;
         end
         acc_cyc++;
      end else begin
         bus.pready = 1'b0;
         bus.prdata = $urandom;
      end
      prev_psel = (bus.psel === 1'b1);
      prev_pen  = (bus.penable === 1'b1);
   end

   // Command-level expectation from the scripted slave behaviour.
   function automatic void model(input bit w, input bit p, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] m, output logic [1:0] er,
                                 output logic [DW-1:0] rd, output int nacc, output int pen);
      pen = 0;
      nacc = 0;
      er = 2'b10;
      rd = '0;
      for (int i = 0; i < PM; i++) begin
         nacc = i + 1;
         if (slv_wait[i] >= TO) begin
            er = 2'b01;
            rd = '0;
            pen += TO;
            return;
         end
         pen += slv_wait[i] + 1;
         rd = w ? '0 : slv_data[i];
         if (w || !p || ((slv_data[i] ^ wd) & m) == '0) begin
            er = 2'b00;
            return;
         end
      end
   endfunction

   task automatic clear_counts();
      setups_seen = 0;
      pen_cnt = 0;
      psel_falls = 0;
   endtask

   task automatic issue(input bit w, input bit p, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] m, output int acc_c);
      int t;
      t = 0;
      bus.cmd_write = w;
      bus.cmd_poll  = p;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      bus.cmd_mask  = m;
      bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1 && t < 100) begin
         @(negedge pclk);
         t++;
      end
      if (bus.cmd_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout cmd_ready=%b required=1", bus.cmd_ready);
      end
      acc_c = cyc;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [DW-1:0] rd, output logic [1:0] er, output int lat);
      int k;
      k = 1;
      while (bus.rsp_valid !== 1'b1 && k < 200) begin
         @(negedge pclk);
         k++;
      end
      if (bus.rsp_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL rsp_timeout rsp_valid=%b required=1", bus.rsp_valid);
      end
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      lat = k;
   endtask

   task automatic ack(input int dly, output bit stable);
      logic [DW-1:0] rd0;
      logic [1:0]    e0;
      rd0 = bus.rsp_rdata;
      e0 = bus.rsp_err;
      stable = 1'b1;
      repeat (dly) begin
         @(negedge pclk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd0 || bus.rsp_err !== e0) stable = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(negedge pclk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.cmd_ready, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 8'b1000_0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b required=10000000",
                  {bus.cmd_ready, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err});
      end
      checks++;
      if (bus.rsp_rdata !== '0 || bus.pwdata !== '0 || bus.paddr !== '0) begin
         failures++;
         $display("FAIL reset_data rdata=%h pwdata=%h paddr=%h required=0", bus.rsp_rdata, bus.pwdata, bus.paddr);
      end
      $display("txn reset cmd_ready=%b busy=%b", bus.cmd_ready, bus.busy);
   endtask

   task automatic test_write();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st;
      slv_wait[0] = 0;
      clear_counts();
      issue(1'b1, 1'b0, 12'h010, 32'hA5A5_0001, '0, ac);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn write addr=010 err=%0d rdata=%h lat=%0d", er, rd, lat);
      checks++;
      if (lat != 3) begin failures++; $display("FAIL write_latency got=%0d required=3", lat); end
      checks++;
      if (er !== 2'b00 || rd !== '0) begin failures++; $display("FAIL write_rsp err=%b rdata=%h required=00/0", er, rd); end
      checks++;
      if (s_wr !== 1'b1 || s_wd !== 32'hA5A5_0001 || s_addr !== 12'h010) begin
         failures++;
         $display("FAIL write_bus pwrite=%b pwdata=%h paddr=%h required=1/a5a50001/010", s_wr, s_wd, s_addr);
      end
      checks++;
      if (pen_cnt != 1 || setups_seen != 1) begin
         failures++;
         $display("FAIL write_phases access=%0d setup=%0d required=1/1", pen_cnt, setups_seen);
      end
   endtask

   task automatic test_read_wait();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st;
      slv_wait[0] = 5;
      slv_data[0] = 32'h1234_5678;
      clear_counts();
      issue(1'b0, 1'b0, 12'h020, $urandom, $urandom, ac);
      wait_rsp(rd, er, lat);
      ack(2, st);
      $display("txn read addr=020 err=%0d rdata=%h lat=%0d", er, rd, lat);
      checks++;
      if (rd !== 32'h1234_5678 || er !== 2'b00) begin
         failures++;
         $display("FAIL read_rsp rdata=%h err=%b required=12345678/00", rd, er);
      end
      checks++;
      if (pen_cnt != 6 || lat != 8) begin
         failures++;
         $display("FAIL read_wait_cycles penable=%0d lat=%0d required=6/8", pen_cnt, lat);
      end
      checks++;
      if (s_wd !== '0 || s_wr !== 1'b0) begin failures++; $display("FAIL read_pwdata pwdata=%h pwrite=%b required=0/0", s_wd, s_wr); end
      checks++;
      if (!st) begin failures++; $display("FAIL read_rsp_hold stable=%0d required=1", st); end
   endtask

   task automatic test_poll();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st;
      slv_wait = '{1, 0, 2, 0, 0, 0, 0, 0};
      slv_data = '{32'h0, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      clear_counts();
      issue(1'b0, 1'b1, 12'h004, 32'h1, 32'h1, ac);
      wait_rsp(rd, er, lat);
      ack(1, st);
      $display("txn poll addr=004 err=%0d rdata=%h accesses=%0d", er, rd, setups_seen);
      checks++;
      if (setups_seen != 3) begin failures++; $display("FAIL poll_attempts got=%0d required=3", setups_seen); end
      checks++;
      if (psel_falls != 1) begin failures++; $display("FAIL poll_psel_held psel_falls=%0d required=1", psel_falls); end
      checks++;
      if (er !== 2'b00 || rd !== 32'h3) begin failures++; $display("FAIL poll_rsp err=%b rdata=%h required=00/3", er, rd); end
   endtask

   task automatic test_poll_exhaust();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st;
      slv_wait = '{0, 0, 0, 0, 0, 0, 0, 0};
      slv_data = '{default: 32'h0};
      clear_counts();
      issue(1'b0, 1'b1, 12'h004, 32'h1, 32'h1, ac);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn poll_exhaust err=%0d rdata=%h accesses=%0d", er, rd, setups_seen);
      checks++;
      if (setups_seen != PM) begin failures++; $display("FAIL exhaust_attempts got=%0d required=%0d", setups_seen, PM); end
      checks++;
      if (er !== 2'b10 || rd !== '0) begin failures++; $display("FAIL exhaust_rsp err=%b rdata=%h required=10/0", er, rd); end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st;
      slv_wait[0] = 1000;
      clear_counts();
      issue(1'b0, 1'b0, 12'h0F0, '0, '0, ac);
      wait_rsp(rd, er, lat);
      checks++;
      if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
         failures++;
         $display("FAIL timeout_bus_release psel=%b penable=%b required=0/0", bus.psel, bus.penable);
      end
      ack(0, st);
      $display("txn timeout err=%0d rdata=%h penable_cycles=%0d", er, rd, pen_cnt);
      checks++;
      if (pen_cnt != TO || lat != TO + 2) begin
         failures++;
         $display("FAIL timeout_cycles penable=%0d lat=%0d required=%0d/%0d", pen_cnt, lat, TO, TO + 2);
      end
      checks++;
      if (er !== 2'b01 || rd !== '0) begin failures++; $display("FAIL timeout_rsp err=%b rdata=%h required=01/0", er, rd); end

      // pready on the very cycle the count reaches TIMEOUT is a completion
      slv_wait[0] = TO - 1;
      slv_data[0] = 32'hCAFE_0008;
      clear_counts();
      issue(1'b0, 1'b0, 12'h0F4, '0, '0, ac);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn edge_read err=%0d rdata=%h penable_cycles=%0d", er, rd, pen_cnt);
      checks++;
      if (er !== 2'b00 || rd !== 32'hCAFE_0008 || pen_cnt != TO) begin
         failures++;
         $display("FAIL timeout_edge err=%b rdata=%h penable=%0d required=00/cafe0008/%0d", er, rd, pen_cnt, TO);
      end

      slv_wait[0] = 1;
      clear_counts();
      issue(1'b1, 1'b0, 12'h0F8, 32'h0000_BEEF, '0, ac);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn followup_write err=%0d lat=%0d", er, lat);
      checks++;
      if (er !== 2'b00 || lat != 4) begin failures++; $display("FAIL followup_write err=%b lat=%0d required=00/4", er, lat); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac1, ac2;
      bit            st;
      slv_wait[0] = 0;
      clear_counts();
      issue(1'b1, 1'b0, 12'h100, 32'h1111_2222, '0, ac1);
      wait_rsp(rd, er, lat);
      // New command raised in the same cycle the response is accepted
      slv_data[0] = 32'h5A5A_0F0F;
      clear_counts();
      bus.cmd_write = 1'b0;
      bus.cmd_poll  = 1'b0;
      bus.cmd_addr  = 12'h104;
      bus.cmd_wdata = '0;
      bus.cmd_mask  = '0;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      @(negedge pclk);
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.psel !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL no_overlap psel=%b cmd_ready=%b required=0/1", bus.psel, bus.cmd_ready);
      end
      issue(1'b0, 1'b0, 12'h104, '0, '0, ac2);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn back_to_back spacing=%0d rdata=%h err=%0d", ac2 - ac1, rd, er);
      checks++;
      if (ac2 - ac1 != 4) begin failures++; $display("FAIL b2b_spacing got=%0d required=4", ac2 - ac1); end
      checks++;
      if (rd !== 32'h5A5A_0F0F || er !== 2'b00 || lat != 3) begin
         failures++;
         $display("FAIL b2b_read rdata=%h err=%b lat=%0d required=5a5a0f0f/00/3", rd, er, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd;
      logic [1:0]    er;
      int            lat, ac;
      bit            st, quiet;
      logic [DW-1:0] d;
      slv_wait[0] = 1000;
      clear_counts();
      issue(1'b0, 1'b0, 12'h200, '0, '0, ac);
      @(negedge pclk);
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      checks++;
      if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset psel=%b penable=%b rsp_valid=%b required=0/0/0", bus.psel, bus.penable, bus.rsp_valid);
      end
      @(negedge pclk);
      presetn = 1'b1;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release cmd_ready=%b busy=%b required=1/0", bus.cmd_ready, bus.busy);
      end
      quiet = 1'b1;
      repeat (4) begin
         @(negedge pclk);
         if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin failures++; $display("FAIL aborted_rsp rsp_valid_seen=1 required=0"); end
      d = $urandom;
      slv_wait[0] = 2;
      slv_data[0] = d;
      clear_counts();
      issue(1'b0, 1'b0, 12'h204, '0, '0, ac);
      wait_rsp(rd, er, lat);
      ack(0, st);
      $display("txn post_reset_read rdata=%h err=%0d lat=%0d", rd, er, lat);
      checks++;
      if (rd !== d || er !== 2'b00 || lat != 5) begin
         failures++;
         $display("FAIL post_reset_read rdata=%h err=%b lat=%0d required=%h/00/5", rd, er, lat, d);
      end
   endtask

   task automatic test_random();
      int            wl [8] = '{0, 0, 0, 1, 2, 3, 7, 12};
      logic [DW-1:0] rd, erd, wd, m;
      logic [1:0]    er, eer;
      int            lat, ac, nacc, pen, dly;
      bit            st, w, p;
      for (int n = 0; n < 40; n++) begin
         w  = ($urandom % 3) == 0;
         p  = $urandom % 2;
         wd = $urandom;
         m  = $urandom;
         if ($urandom % 2) m = m & 32'hFF;
         for (int i = 0; i < 8; i++) begin
            slv_wait[i] = wl[$urandom % 8];
            slv_data[i] = (($urandom % 3) == 0) ? ((wd & m) | ($urandom & ~m)) : $urandom;
         end
         model(w, p, wd, m, eer, erd, nacc, pen);
         dly = $urandom % 3;
         clear_counts();
         issue(w, p, AW'($urandom), wd, m, ac);
         wait_rsp(rd, er, lat);
         ack(dly, st);
         $display("txn rand%0d w=%0d p=%0d err=%0d rdata=%h acc=%0d lat=%0d", n, w, p, er, rd, setups_seen, lat);
         checks++;
         if (er !== eer) begin failures++; $display("FAIL rand%0d_err got=%b required=%b", n, er, eer); end
         checks++;
         if (rd !== erd) begin failures++; $display("FAIL rand%0d_rdata got=%h required=%h", n, rd, erd); end
         checks++;
         if (setups_seen != nacc) begin failures++; $display("FAIL rand%0d_accesses got=%0d required=%0d", n, setups_seen, nacc); end
         checks++;
         if (pen_cnt != pen) begin failures++; $display("FAIL rand%0d_penable got=%0d required=%0d", n, pen_cnt, pen); end
         checks++;
         if (lat != nacc + pen + 1) begin failures++; $display("FAIL rand%0d_latency got=%0d required=%0d", n, lat, nacc + pen + 1); end
         checks++;
         if (!st) begin failures++; $display("FAIL rand%0d_rsp_hold stable=%0d required=1", n, st); end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (viol != 0) begin failures++; $display("FAIL apb_protocol violations=%0d required=0", viol); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_poll  = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_mask  = '0;
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b0;
      bus.prdata    = '0;
      for (int i = 0; i < 8; i++) begin
         slv_wait[i] = 0;
         slv_data[i] = '0;
      end
      #2 presetn = 1'b0;
      repeat (3) @(negedge pclk);
      test_reset();
      presetn = 1'b1;
      @(negedge pclk);
      test_write();
      test_read_wait();
      test_poll();
      test_poll_exhaust();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tlrb_aib_apb_master.md
Name: tlrb_aib_apb_master

Overview:
APB initiator that drives the APB slave configuration port of the TLRB AIB PHY (paddr/psel/penable/pwrite/pwdata in, prdata/pready out). It accepts single-register commands from a local sequencer or test controller over a valid/ready interface. It performs APB write, read, and read-poll transfers, and returns one response per command with the read data and an error code. It sits in the pclk domain next to the PHY, one instance per AIB channel.

Parameters:
AW, 12, APB address width; matches the PHY paddr width.
DW, 32, APB data width; matches the PHY pwdata/prdata width.
TIMEOUT, 255, cycles in ACCESS with pready low before the transfer is abandoned; must be at least 1.
POLL_MAX, 1023, maximum number of read attempts for a poll command; must be at least 1.

Ports:
pclk  in  1  APB clock; the only clock in the block.
presetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accept; high only in IDLE.
cmd_write  in  1  1 = write, 0 = read.
cmd_poll  in  1  read-poll enable; ignored when cmd_write=1.
cmd_addr  in  AW  register address.
cmd_wdata  in  DW  write data, or poll compare value.
cmd_mask  in  DW  poll compare mask.
rsp_valid  out  1  response available.
rsp_ready  in  1  response accept.
rsp_rdata  out  DW  last captured prdata; 0 for writes.
rsp_err  out  2  00 = OK, 01 = pready timeout, 10 = poll exhausted, 11 = reserved, never driven.
busy  out  1  high in any state other than IDLE.
paddr  out  AW  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  DW  APB write data; 0 during reads.
prdata  in  DW  APB read data.
pready  in  1  APB ready.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchronizer):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready, which goes to 1.
  - The timeout counter and the poll counter clear.
  - Reset asserted mid-transfer drops psel and penable immediately. No response is produced for the aborted command.
- States are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, the block registers cmd_* and moves to SETUP.
  - The poll counter is set to 1 on acceptance.
- SETUP (exactly one cycle):
  - psel=1, penable=0.
  - paddr, pwrite and pwdata are driven from the registered command.
  - Moves to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - All APB outputs are held stable until exit.
  - The timeout counter increments each cycle that pready=0.
- ACCESS completion with pready=1:
  - prdata is captured into rsp_rdata for reads.
  - A write, or a read without poll, goes to RESP with err=00.
  - A poll read with (prdata & mask) == (wdata & mask) goes to RESP with err=00.
  - A poll read that mismatches with poll counter < POLL_MAX increments the poll counter and returns to SETUP for the retry. On that SETUP cycle psel stays 1 and penable goes to 0; the bus is not released.
  - A poll read that mismatches with poll counter == POLL_MAX goes to RESP with err=10. rsp_rdata holds the last prdata.
- ACCESS timeout:
  - When the counter reaches TIMEOUT while pready=0, the block goes to RESP with err=01 and rsp_rdata=0.
  - psel and penable go to 0 in the next cycle.
  - pready=1 on the same cycle the counter reaches TIMEOUT counts as completion; completion wins over timeout.
  - The timeout counter clears on every SETUP entry.
- RESP:
  - psel=0, penable=0.
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, returns to IDLE.
  - rsp_valid and rsp_ready in the same cycle that a new cmd_valid arrives: the new command is accepted only in the following IDLE cycle. There is no overlap.
- paddr, pwrite and pwdata hold their last values when psel=0.
- Latency with pready=1 on the first ACCESS cycle:
  - Accept cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
  - Minimum command-to-command spacing is 4 cycles.
- Counter widths:
  - Timeout counter is clog2(TIMEOUT+1) bits.
  - Poll counter is clog2(POLL_MAX+1) bits.
  - Neither counter ever wraps.
- Protocol invariants:
  - penable=1 only when psel=1.
  - penable never rises without a preceding SETUP cycle.

Test Plan:
1. Write 0x010 = 0xA5A5_0001, pready tied 1 → SETUP and ACCESS one cycle each, pwrite=1, pwdata=0xA5A5_0001. rsp_valid 3 cycles after accept, err=00, rdata=0.
2. Read 0x020; slave holds pready low 5 cycles, then returns 0x1234_5678 → penable high for 6 cycles with paddr stable, rsp_rdata=0x1234_5678, err=00.
3. Poll 0x004, mask=0x1, wdata=0x1; slave returns 0x0, 0x0, then 0x3 → three SETUP/ACCESS pairs with psel continuously high, err=00, rdata=0x3.
4. Poll with POLL_MAX=4; slave always returns 0 → exactly 4 accesses, err=10, rdata=0.
5. TIMEOUT=8 with pready stuck 0 → penable high for 8 cycles, then psel=penable=0, err=01. A follow-up write with a normal slave completes with err=00.
6. presetn pulsed low during ACCESS → psel and penable drop asynchronously, no rsp_valid, cmd_ready=1 after reset release. A new read completes normally.
